mips_multicycle_ls: RTL
=======================

# mips_multicycle_ls

Multicycle MIPS load/store core and the next generation of the single-cycle `lw` datapath. It fetches instructions and accesses data through one shared, variable-latency memory port with a req/ack handshake. It executes `lw`, `sw` and `addi` through a state machine, with parametrised address width and reset PC. It contains its own 32×32 register file and sign extender, and it exposes a debug register read port for benches.

## Interface
Parameters:
- ADDR_W, 16, byte-address width of `pc` and `mem_addr`. Legal range is 8 to 32.
- RESET_PC, 0, value loaded into `pc` at reset. Must be a multiple of 4.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  1 means write, 0 means read. Valid while `mem_req` is high.
- mem_addr  out  ADDR_W  byte address. Bits [1:0] are 0 for word accesses.
- mem_be  out  4  byte-lane enables. Lane 0 is bits [7:0] (little-endian).
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data. Valid in the cycle `mem_ack` is high.
- mem_ack  in  1  completes the current request.
- pc  out  ADDR_W  address of the next instruction to fetch.
- state  out  3  current FSM state encoding.
- halt  out  1  core stopped.
- illegal  out  1  the halt was caused by an unsupported opcode.
- dbg_ra  in  5  debug register address.
- dbg_rd  out  32  combinational `rf[dbg_ra]`. Reads 0 when `dbg_ra` = 0.

## Operation
- Instruction formats:
  - I-type fields: op = [31:26], rs = [25:21], rt = [20:16], imm = [15:0].
  - simm = the 16-bit immediate sign-extended to 32 bits.
  - ea = (rf[rs] + simm), truncated to ADDR_W bits.
- Supported opcodes:
  - `lw` (35): rf[rt] = mem[ea & ~3].
  - `sw` (43): mem[ea & ~3] = rf[rt].
  - `addi` (8): rf[rt] = rf[rs] + simm, modulo 2^32, no overflow trap.
  - `halt` (63): stop, with `illegal` = 0.
  - Any other opcode: stop, with `illegal` = 1.
- Word accesses ignore ea[1:0] and drive `mem_be` = 4'b1111.
- Register file:
  - Writes to r0 are discarded; r0 always reads 0.
  - All registers are cleared on reset.
- FSM states and transitions:
  - FETCH (0): issues a read at `pc`. On ack, latches the instruction, sets `pc` += 4 (wraps modulo 2^ADDR_W), goes to DECODE.
  - DECODE (1): latches rf[rs] and rf[rt]. Next state is EXEC for lw/sw/addi/lb/sb, otherwise HALT.
  - EXEC (2): computes ea or the addi sum into aluout. Next state is MEMRD (lw/lb), MEMWR (sw/sb) or ALUWB (addi).
  - MEMRD (3): issues a read at aluout. On ack, latches the data and goes to MEMWB.
  - MEMWB (4): writes rf[rt] from the latched data, then goes to FETCH.
  - MEMWR (5): issues a write. On ack, goes to FETCH.
  - ALUWB (6): writes rf[rt] = aluout, then goes to FETCH.
  - HALT (7): terminal; only reset leaves it. `halt` = 1.
- Handshake rules:
  - `mem_req` rises on entry to FETCH, MEMRD or MEMWR.
  - `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` stay stable until the edge at which `mem_ack` is sampled high.
  - `mem_req` drops in the following cycle.
  - An ack arriving while `mem_req` = 0 is ignored.
  - Wait states are unbounded.

## Timing
- Reset values:
  - `pc` = RESET_PC, `state` = FETCH.
  - `mem_req` = 1 in the first cycle after `rst_n` rises; all other outputs are 0.
  - While `rst_n` = 0: `mem_req`, `mem_we`, `mem_be`, `mem_wdata`, `halt`, `illegal` are all 0.
- Cycles per instruction with zero-wait ack (ack high in the first req cycle):
  - `lw` = 5.
  - `sw` = 4.
  - `addi` = 4.
  - Each wait cycle adds 1.
- Reset asserted mid-transaction aborts immediately. No write completes, and memory must treat the dropped `mem_req` as a cancel.
- Register write and debug read in the same cycle: `dbg_rd` shows the old value until the clock edge.

## Configuration
- With `MIPS_LS_BYTE_EN` defined, two byte opcodes are added:
  - `lb` (32): reads the word at ea & ~3, selects byte ea[1:0], sign-extends it into rf[rt].
  - `sb` (40): `mem_be` = 1 << ea[1:0], and `mem_wdata` replicates rf[rt][7:0] into all four lanes.
  - Both take the same cycle counts as `lw`/`sw`.
- Without the macro:
  - Opcodes 32 and 40 are illegal: HALT with `illegal` = 1.
  - `mem_be` is always 4'b1111 during requests.

## Test plan
- Reset with RESET_PC = 0 → `pc` = 0, `state` = 0, `mem_req` = 1 after `rst_n` rises, `halt` = 0.
- Program:
  - `addi $20,$0,8`
  - `lw $19,4($20)` with mem[12] = 999
  - `halt`
  - Expected: read request at `mem_addr` = 12; `dbg_rd`(19) = 999; `dbg_rd`(20) = 8; `halt` = 1, `illegal` = 0. Zero-wait total = 4 + 5 + 3 cycles.
- `sw $19,0($0)` with r19 = 0xDEADBEEF and ack delayed 3 cycles → `mem_req`/`mem_we` = 1 for 4 cycles with addr 0 and wdata 0xDEADBEEF held stable; the next fetch is at `pc` = 4.
- Opcode 0x2A fetched → HALT with `illegal` = 1; no further `mem_req`.
- `addi $0,$0,5` then `addi $1,$0,-1` → r0 reads 0; r1 = 0xFFFFFFFF.
- `rst_n` pulled low during a MEMWR wait state → `mem_req` drops asynchronously; after release, fetch restarts at RESET_PC.
- With `MIPS_LS_BYTE_EN` defined, `lb` with ea = 13 and mem[12] = 0x0080FF00 → r[rt] = 0xFFFFFFFF. `sb` with ea = 14 → `mem_be` = 4'b0100.

Source files
------------

// File: rtl/mips_multicycle_ls.sv
// Multicycle MIPS core running lw/sw/addi over one shared req/ack memory port.
// Define MIPS_LS_BYTE_EN to add the lb/sb byte opcodes; without it they halt as illegal.
module mips_multicycle_ls #(
    parameter int          ADDR_W   = 16,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halt,
    output logic              illegal,
    input  logic [4:0]        dbg_ra,
    output logic [31:0]       dbg_rd
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMRD  = 3'd3,
        S_MEMWB  = 3'd4,
        S_MEMWR  = 3'd5,
        S_ALUWB  = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LB   = 6'd32;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SB   = 6'd40;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] OP_HALT = 6'd63;

`ifdef MIPS_LS_BYTE_EN
    localparam logic BYTE_EN = 1'b1;
`else
    localparam logic BYTE_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q, a_q, b_q, alu_q, mdr_q;
    logic              illegal_q;
    logic [31:0]       rf [32];

    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [31:0] simm;
    logic        is_lb, is_sb, is_load, is_store, is_addi, is_supported;
    logic        mem_state;
    logic [7:0]  ld_byte;
    logic        rf_we;
    logic [31:0] rf_wdata;

    assign op   = ir_q[31:26];
    assign rs   = ir_q[25:21];
    assign rt   = ir_q[20:16];
    assign simm = {{16{ir_q[15]}}, ir_q[15:0]};

    assign is_lb        = BYTE_EN && (op == OP_LB);
    assign is_sb        = BYTE_EN && (op == OP_SB);
    assign is_load      = (op == OP_LW) || is_lb;
    assign is_store     = (op == OP_SW) || is_sb;
    assign is_addi      = (op == OP_ADDI);
    assign is_supported = is_load || is_store || is_addi;

    // The reset gate makes mem_req fall the instant rst_n drops, cancelling any open request.
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign mem_req   = rst_n && mem_state;
    assign mem_we    = (state_q == S_MEMWR);
    assign mem_addr  = (state_q == S_FETCH) ? pc_q : {alu_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        if (mem_req) begin
            mem_be = 4'b1111;
        end
        if (state_q == S_MEMWR) begin
            mem_wdata = is_sb ? {4{b_q[7:0]}} : b_q;
            if (is_sb) begin
                mem_be = 4'b0001 << alu_q[1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ack) state_d = S_DECODE;
            S_DECODE: state_d = is_supported ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (is_load)       state_d = S_MEMRD;
                else if (is_store) state_d = S_MEMWR;
                else               state_d = S_ALUWB;
            end
            S_MEMRD:  if (mem_ack) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ack) state_d = S_FETCH;
            S_ALUWB:  state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC[ADDR_W-1:0];
            ir_q      <= 32'h0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            alu_q     <= 32'h0;
            mdr_q     <= 32'h0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir_q <= mem_rdata;
                        pc_q <= pc_q + ADDR_W'(4);
                    end
                end
                S_DECODE: begin
                    a_q <= rf[rs];
                    b_q <= rf[rt];
                    if (!is_supported && (op != OP_HALT)) begin
                        illegal_q <= 1'b1;
                    end
                end
                S_EXEC:  alu_q <= a_q + simm;
                S_MEMRD: if (mem_ack) mdr_q <= mem_rdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        ld_byte = mdr_q[7:0];
        case (alu_q[1:0])
            2'd1:    ld_byte = mdr_q[15:8];
            2'd2:    ld_byte = mdr_q[23:16];
            2'd3:    ld_byte = mdr_q[31:24];
            default: ld_byte = mdr_q[7:0];
        endcase
    end

    always_comb begin
        rf_wdata = alu_q;
        if (state_q == S_MEMWB) begin
            rf_wdata = is_lb ? {{24{ld_byte[7]}}, ld_byte} : mdr_q;
        end
    end

    assign rf_we = ((state_q == S_MEMWB) || (state_q == S_ALUWB)) && (rt != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the register file is cleared on reset, so it maps to flops rather than a RAM macro.
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'h0;
            end
        end else if (rf_we) begin
            rf[rt] <= rf_wdata;
        end
    end

    assign dbg_rd  = (dbg_ra == 5'd0) ? 32'h0 : rf[dbg_ra];
    assign pc      = pc_q;
    assign state   = state_q;
    assign halt    = (state_q == S_HALT);
    assign illegal = illegal_q;

endmodule
